// File: rtl/custom_axi_to_mem_responder_if.sv
// AXI4 slave-side bundle for custom_axi_to_mem_responder: AW, W, B, AR and R channels.
// The master modport is the initiator view; the slave modport is the responder view.
interface custom_axi_to_mem_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 2
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;

    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input bid, bresp, bvalid, output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
        input rid, rdata, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
        input wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input arid, araddr, arlen, arsize, arburst, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready
    );
endinterface

// File: rtl/custom_axi_to_mem_responder.sv
// AXI4 responder that serves one burst at a time from a single-beat MEM port,
// with one outstanding MEM request and alternating read/write arbitration.
module custom_axi_to_mem_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    custom_axi_to_mem_responder_if.slave s_axi,
    output logic                    mem_req,
    input  logic                    mem_gnt,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_we,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_valid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_error
);
    localparam int STRB = DATA_WIDTH / 8;
    localparam int LSB  = $clog2(STRB);

    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_WAIT, RD_RESP, WR_DATA, WR_REQ, WR_WAIT, WR_RESP
    } state_t;

    state_t state, state_nxt;

    logic                  prio_write;
    logic [ID_WIDTH-1:0]   id_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [2:0]            size_q;
    logic                  fixed_q;
    logic                  bad_q;
    logic [7:0]            beat_q;
    logic                  err_sticky;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rerr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB-1:0]       wstrb_q;

    logic                  last_beat;
    logic [ADDR_WIDTH-1:0] addr_next;

    assign last_beat = (beat_q == len_q);
    assign addr_next = fixed_q ? addr_q : addr_q + (ADDR_WIDTH'(1) << size_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // WRAP/reserved bursts (burst[1] set) bypass the MEM side entirely.
    always_comb begin
        state_nxt     = state;
        s_axi.arready = 1'b0;
        s_axi.awready = 1'b0;
        case (state)
            IDLE: begin
                s_axi.arready = s_axi.arvalid && (!s_axi.awvalid || !prio_write);
                s_axi.awready = s_axi.awvalid && !s_axi.arready;
                if (s_axi.arready)      state_nxt = s_axi.arburst[1] ? RD_RESP : RD_REQ;
                else if (s_axi.awready) state_nxt = WR_DATA;
            end
            RD_REQ:  if (mem_gnt)   state_nxt = RD_WAIT;
            RD_WAIT: if (mem_valid) state_nxt = RD_RESP;
            RD_RESP: if (s_axi.rready) state_nxt = last_beat ? IDLE : (bad_q ? RD_RESP : RD_REQ);
            WR_DATA: if (s_axi.wvalid) state_nxt = bad_q ? (last_beat ? WR_RESP : WR_DATA) : WR_REQ;
            WR_REQ:  if (mem_gnt)   state_nxt = WR_WAIT;
            WR_WAIT: if (mem_valid) state_nxt = last_beat ? WR_RESP : WR_DATA;
            WR_RESP: if (s_axi.bready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_write <= 1'b0;
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            size_q     <= '0;
            fixed_q    <= 1'b0;
            bad_q      <= 1'b0;
            beat_q     <= '0;
            err_sticky <= 1'b0;
            rdata_q    <= '0;
            rerr_q     <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_axi.arready) begin
                        id_q       <= s_axi.arid;
                        addr_q     <= s_axi.araddr;
                        len_q      <= s_axi.arlen;
                        size_q     <= s_axi.arsize;
                        fixed_q    <= (s_axi.arburst == 2'b00);
                        bad_q      <= s_axi.arburst[1];
                        rerr_q     <= s_axi.arburst[1];
                        rdata_q    <= '0;
                        beat_q     <= '0;
                        err_sticky <= 1'b0;
                        prio_write <= 1'b1;
                    end else if (s_axi.awready) begin
                        id_q       <= s_axi.awid;
                        addr_q     <= s_axi.awaddr;
                        len_q      <= s_axi.awlen;
                        size_q     <= s_axi.awsize;
                        fixed_q    <= (s_axi.awburst == 2'b00);
                        bad_q      <= s_axi.awburst[1];
                        beat_q     <= '0;
                        err_sticky <= 1'b0;
                        prio_write <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    if (mem_valid) begin
                        rdata_q <= mem_rdata;
                        rerr_q  <= mem_error;
                    end
                end
                RD_RESP: begin
                    if (s_axi.rready && !last_beat) begin
                        beat_q <= beat_q + 8'd1;
                        addr_q <= addr_next;
                    end
                end
                WR_DATA: begin
                    if (s_axi.wvalid) begin
                        wdata_q <= s_axi.wdata;
                        wstrb_q <= s_axi.wstrb;
                        if ((s_axi.wlast != last_beat) || bad_q) err_sticky <= 1'b1;
                        if (bad_q && !last_beat) beat_q <= beat_q + 8'd1;
                    end
                end
                WR_WAIT: begin
                    if (mem_valid) begin
                        if (mem_error) err_sticky <= 1'b1;
                        if (!last_beat) begin
                            beat_q <= beat_q + 8'd1;
                            addr_q <= addr_next;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_req   = (state == RD_REQ) || (state == WR_REQ);
    assign mem_we    = (state == WR_REQ);
    assign mem_be    = (state == WR_REQ) ? wstrb_q : '1;
    assign mem_addr  = {addr_q[ADDR_WIDTH-1:LSB], LSB'(0)};
    assign mem_wdata = wdata_q;

    assign s_axi.wready = (state == WR_DATA);
    assign s_axi.rvalid = (state == RD_RESP);
    assign s_axi.rid    = id_q;
    assign s_axi.rdata  = rdata_q;
    assign s_axi.rresp  = rerr_q ? 2'b10 : 2'b00;
    assign s_axi.rlast  = last_beat;
    assign s_axi.bvalid = (state == WR_RESP);
    assign s_axi.bid    = id_q;
    assign s_axi.bresp  = err_sticky ? 2'b10 : 2'b00;
endmodule

// File: tb/tb_custom_axi_to_mem_responder.sv
// Bench for custom_axi_to_mem_responder: a word-array memory with random grant/latency,
// queue-based expectations derived from burst arithmetic, and a per-cycle compare process.
module tb_custom_axi_to_mem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_gnt, mem_we, mem_valid, mem_error;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int total = 0;
    int bad   = 0;
    bit det   = 1'b1;
    bit slow  = 1'b0;

    always #5 clk = ~clk;

    custom_axi_to_mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(2)) axi ();

    custom_axi_to_mem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(2)) dut (
        .clk(clk), .rst(rst), .s_axi(axi),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_valid(mem_valid),
        .mem_rdata(mem_rdata), .mem_error(mem_error)
    );

    typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } mop_t;
    typedef struct { logic [1:0] id; logic [31:0] data; logic [1:0] resp; logic last; } rb_t;
    typedef struct { logic [1:0] id; logic [1:0] resp; } bb_t;

    mop_t mq[$];
    rb_t  rq[$];
    bb_t  bq[$];

    logic [31:0] obs_addr[$];
    logic        obs_we[$];
    logic [3:0]  obs_be[$];
    logic [31:0] obs_rdata[$];
    logic [1:0]  obs_rresp[$];
    logic        obs_rlast[$];
    logic [1:0]  obs_bresp[$];

    logic [31:0] mem_words [0:1023];
    logic [31:0] w_data [0:255];
    logic [3:0]  w_strb [0:255];
    logic        w_last [0:255];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: event did not occur as required", name);
    endtask

    function automatic logic [31:0] beat_addr(logic [31:0] a, logic [2:0] size, logic [1:0] burst, int k);
        return (burst == 2'b00) ? a : a + (32'(k) << size);
    endfunction

    function automatic bit err_at(logic [31:0] a);
        return a[11:8] == 4'hE;
    endfunction

    // Memory: applies writes at grant, answers 1+d cycles later, errors in 0xE00-0xEFF.
    initial begin : mem_model
        bit          has_pend, fire, fwe;
        int          pend, d;
        logic [31:0] prd, fa, fwd;
        logic [3:0]  fbe;
        logic        perr;
        has_pend = 0; pend = 0; prd = '0; perr = 1'b0;
        mem_gnt = 1'b0; mem_valid = 1'b0; mem_rdata = '0; mem_error = 1'b0;
        forever begin
            @(negedge clk);
            fire = !rst && mem_req && mem_gnt;
            fa = mem_addr; fwd = mem_wdata; fwe = mem_we; fbe = mem_be;
            @(posedge clk); #1;
            mem_valid = 1'b0; mem_error = 1'b0; mem_rdata = $urandom;
            if (has_pend) begin
                pend--;
                if (pend == 0) begin
                    mem_valid = 1'b1; mem_rdata = prd; mem_error = perr; has_pend = 0;
                end
            end else if (fire) begin
                perr = err_at(fa);
                if (fwe) begin
                    for (int b = 0; b < 4; b++)
                        if (fbe[b]) mem_words[fa[11:2]][8*b +: 8] = fwd[8*b +: 8];
                    prd = $urandom;
                end else begin
                    prd = mem_words[fa[11:2]];
                end
                d = slow ? 3 : (det ? 0 : int'($urandom_range(0, 2)));
                if (d == 0) begin
                    mem_valid = 1'b1; mem_rdata = prd; mem_error = perr;
                end else begin
                    has_pend = 1; pend = d;
                end
            end else if (!det && $urandom_range(0, 7) == 0) begin
                mem_valid = 1'b1; mem_error = 1'($urandom_range(0, 1));
            end
            mem_gnt = det ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
    end

    initial begin : resp_ready
        axi.rready = 1'b0; axi.bready = 1'b0;
        forever begin
            @(posedge clk); #1;
            axi.rready = det ? 1'b1 : ($urandom_range(0, 2) != 0);
            axi.bready = det ? 1'b1 : ($urandom_range(0, 2) != 0);
        end
    end

    initial begin : compare
        logic        p_req, p_gnt, p_we, p_rv, p_rr, p_rl;
        logic [31:0] p_addr, p_wd, p_rd;
        logic [3:0]  p_be;
        logic [1:0]  p_rresp;
        mop_t m; rb_t r; bb_t b;
        p_req = 0; p_gnt = 0; p_we = 0; p_rv = 0; p_rr = 0; p_rl = 0;
        p_addr = '0; p_wd = '0; p_rd = '0; p_be = '0; p_rresp = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                p_req = 0; p_rv = 0;
            end else begin
                if (p_req && !p_gnt) begin
                    chk("mem_req_held", mem_req, 1'b1);
                    chk("mem_addr_stable", mem_addr, p_addr);
                    chk("mem_we_stable", mem_we, p_we);
                    chk("mem_be_stable", mem_be, p_be);
                    chk("mem_wdata_stable", mem_wdata, p_wd);
                end
                if (p_rv && !p_rr) begin
                    chk("rvalid_held", axi.rvalid, 1'b1);
                    chk("rdata_stable", axi.rdata, p_rd);
                    chk("rresp_stable", axi.rresp, p_rresp);
                    chk("rlast_stable", axi.rlast, p_rl);
                end
                if (mem_req && mem_gnt) begin
                    obs_addr.push_back(mem_addr); obs_we.push_back(mem_we); obs_be.push_back(mem_be);
                    if (mq.size() == 0) fail("mem_unexpected_req");
                    else begin
                        m = mq.pop_front();
                        chk("mem_addr", mem_addr, m.addr);
                        chk("mem_we", mem_we, m.we);
                        chk("mem_be", mem_be, m.be);
                        if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
                    end
                end
                if (axi.rvalid && axi.rready) begin
                    obs_rdata.push_back(axi.rdata); obs_rresp.push_back(axi.rresp); obs_rlast.push_back(axi.rlast);
                    if (rq.size() == 0) fail("r_unexpected_beat");
                    else begin
                        r = rq.pop_front();
                        chk("rid", axi.rid, r.id);
                        chk("rdata", axi.rdata, r.data);
                        chk("rresp", axi.rresp, r.resp);
                        chk("rlast", axi.rlast, r.last);
                    end
                end
                if (axi.bvalid && axi.bready) begin
                    obs_bresp.push_back(axi.bresp);
                    if (bq.size() == 0) fail("b_unexpected_resp");
                    else begin
                        b = bq.pop_front();
                        chk("bid", axi.bid, b.id);
                        chk("bresp", axi.bresp, b.resp);
                    end
                end
                p_req = mem_req; p_gnt = mem_gnt; p_addr = mem_addr; p_we = mem_we;
                p_be = mem_be; p_wd = mem_wdata;
                p_rv = axi.rvalid; p_rr = axi.rready; p_rd = axi.rdata;
                p_rresp = axi.rresp; p_rl = axi.rlast;
            end
        end
    end

    task automatic obs_clear();
        obs_addr.delete(); obs_we.delete(); obs_be.delete();
        obs_rdata.delete(); obs_rresp.delete(); obs_rlast.delete(); obs_bresp.delete();
    endtask

    task automatic exp_read(input logic [1:0] id, input logic [31:0] a, input int len,
                            input logic [2:0] size, input logic [1:0] burst);
        mop_t m; rb_t r; logic [31:0] ma;
        for (int k = 0; k <= len; k++) begin
            r.id = id; r.last = (k == len);
            if (burst[1]) begin
                r.data = '0; r.resp = 2'b10;
            end else begin
                ma = beat_addr(a, size, burst, k) & 32'hFFFF_FFFC;
                m.addr = ma; m.we = 1'b0; m.be = 4'hF; m.wdata = '0;
                mq.push_back(m);
                r.data = mem_words[ma[11:2]];
                r.resp = err_at(ma) ? 2'b10 : 2'b00;
            end
            rq.push_back(r);
        end
    endtask

    task automatic exp_write(input logic [1:0] id, input logic [31:0] a, input int len,
                             input logic [2:0] size, input logic [1:0] burst);
        mop_t m; bb_t b; logic [31:0] ma; bit e;
        e = burst[1];
        for (int k = 0; k <= len; k++) begin
            if (w_last[k] != (k == len)) e = 1;
            if (!burst[1]) begin
                ma = beat_addr(a, size, burst, k) & 32'hFFFF_FFFC;
                if (err_at(ma)) e = 1;
                m.addr = ma; m.we = 1'b1; m.be = w_strb[k]; m.wdata = w_data[k];
                mq.push_back(m);
            end
        end
        b.id = id; b.resp = e ? 2'b10 : 2'b00;
        bq.push_back(b);
    endtask

    task automatic fill_w(input int len, input int bad_beat, input bit full_strb);
        for (int k = 0; k <= len; k++) begin
            w_data[k] = $urandom;
            w_strb[k] = full_strb ? 4'hF : 4'($urandom_range(1, 15));
            w_last[k] = (k == len) ^ (k == bad_beat);
        end
    endtask

    task automatic ar_go(input logic [1:0] id, input logic [31:0] a, input int len,
                         input logic [2:0] size, input logic [1:0] burst);
        int n;
        @(posedge clk); #1;
        axi.arid = id; axi.araddr = a; axi.arlen = 8'(len); axi.arsize = size;
        axi.arburst = burst; axi.arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!axi.arready && n < 2000);
        if (!axi.arready) fail("ar_handshake_timeout");
        @(posedge clk); #1;
        axi.arvalid = 1'b0;
    endtask

    task automatic aw_go(input logic [1:0] id, input logic [31:0] a, input int len,
                         input logic [2:0] size, input logic [1:0] burst);
        int n;
        @(posedge clk); #1;
        axi.awid = id; axi.awaddr = a; axi.awlen = 8'(len); axi.awsize = size;
        axi.awburst = burst; axi.awvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!axi.awready && n < 2000);
        if (!axi.awready) fail("aw_handshake_timeout");
        @(posedge clk); #1;
        axi.awvalid = 1'b0;
    endtask

    // Caller is positioned just after a rising edge.
    task automatic w_send(input int len);
        int n;
        for (int k = 0; k <= len; k++) begin
            if (!det) begin
                repeat ($urandom_range(0, 2)) begin axi.wvalid = 1'b0; @(posedge clk); #1; end
            end
            axi.wdata = w_data[k]; axi.wstrb = w_strb[k]; axi.wlast = w_last[k]; axi.wvalid = 1'b1;
            n = 0;
            do begin @(negedge clk); n++; end while (!axi.wready && n < 2000);
            if (!axi.wready) fail("w_handshake_timeout");
            @(posedge clk); #1;
        end
        axi.wvalid = 1'b0;
    endtask

    task automatic drain(input int max);
        int n;
        n = 0;
        while ((mq.size() != 0 || rq.size() != 0 || bq.size() != 0) && n < max) begin
            @(posedge clk); n++;
        end
        if (n >= max) begin
            fail("drain_timeout");
            mq.delete(); rq.delete(); bq.delete();
        end
        @(posedge clk);
    endtask

    task automatic do_read(input logic [1:0] id, input logic [31:0] a, input int len,
                           input logic [2:0] size, input logic [1:0] burst);
        exp_read(id, a, len, size, burst);
        ar_go(id, a, len, size, burst);
        drain((len + 1) * 60 + 200);
    endtask

    task automatic do_write(input logic [1:0] id, input logic [31:0] a, input int len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input int bad_beat, input bit full_strb);
        fill_w(len, bad_beat, full_strb);
        exp_write(id, a, len, size, burst);
        aw_go(id, a, len, size, burst);
        w_send(len);
        drain((len + 1) * 60 + 200);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mq.delete(); rq.delete(); bq.delete();
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int          len, n;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [31:0] a;
        for (int i = 0; i < 1024; i++) mem_words[i] = $urandom;
        axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0; axi.awvalid = 1'b0;
        axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0;
        axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0; axi.arburst = '0; axi.arvalid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_arready", axi.arready, 1'b0);
        chk("rst_awready", axi.awready, 1'b0);
        chk("rst_wready", axi.wready, 1'b0);
        chk("rst_rvalid", axi.rvalid, 1'b0);
        chk("rst_bvalid", axi.bvalid, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_rresp", axi.rresp, 2'b00);
        chk("rst_bresp", axi.bresp, 2'b00);
        @(posedge clk); #1 rst = 1'b0;

        // Single read latency: handshake cycle 0, mem_req cycle 1, rvalid cycle 3.
        mem_words[32'h100 >> 2] = 32'hDEAD_BEEF;
        exp_read(2'd1, 32'h100, 0, 3'd2, 2'b01);
        @(posedge clk); #1;
        axi.arid = 2'd1; axi.araddr = 32'h100; axi.arlen = 8'd0; axi.arsize = 3'd2;
        axi.arburst = 2'b01; axi.arvalid = 1'b1;
        @(negedge clk); chk("t1_arready_c0", axi.arready, 1'b1);
        @(posedge clk); #1 axi.arvalid = 1'b0;
        @(negedge clk); chk("t1_mem_req_c1", mem_req, 1'b1);
        @(negedge clk); chk("t1_rvalid_c2", axi.rvalid, 1'b0);
        @(negedge clk);
        chk("t1_rvalid_c3", axi.rvalid, 1'b1);
        chk("t1_rdata", axi.rdata, 32'hDEAD_BEEF);
        chk("t1_rresp", axi.rresp, 2'b00);
        chk("t1_rlast", axi.rlast, 1'b1);
        drain(100);

        // INCR write of four words.
        obs_clear();
        do_write(2'd2, 32'h200, 3, 3'd2, 2'b01, -1, 1'b1);
        chk("t2_nreq", obs_addr.size(), 4);
        if (obs_addr.size() == 4) begin
            chk("t2_addr0", obs_addr[0], 32'h200);
            chk("t2_addr1", obs_addr[1], 32'h204);
            chk("t2_addr2", obs_addr[2], 32'h208);
            chk("t2_addr3", obs_addr[3], 32'h20C);
            chk("t2_we3", obs_we[3], 1'b1);
        end
        chk("t2_nb", obs_bresp.size(), 1);
        if (obs_bresp.size() == 1) chk("t2_bresp", obs_bresp[0], 2'b00);

        // FIXED byte-sized read at unaligned address.
        obs_clear();
        do_read(2'd1, 32'h303, 1, 3'd0, 2'b00);
        chk("t3_nreq", obs_addr.size(), 2);
        if (obs_addr.size() == 2) begin
            chk("t3_addr0", obs_addr[0], 32'h300);
            chk("t3_addr1", obs_addr[1], 32'h300);
            chk("t3_be0", obs_be[0], 4'hF);
        end
        chk("t3_nr", obs_rlast.size(), 2);
        if (obs_rlast.size() == 2) begin
            chk("t3_rlast0", obs_rlast[0], 1'b0);
            chk("t3_rlast1", obs_rlast[1], 1'b1);
        end

        // Arbitration: read wins after reset, then write wins against the next read.
        do_reset();
        fill_w(1, -1, 1'b0);
        exp_read(2'd0, 32'h010, 0, 3'd2, 2'b01);
        exp_write(2'd3, 32'h020, 1, 3'd2, 2'b01);
        exp_read(2'd2, 32'h040, 0, 3'd2, 2'b01);
        @(posedge clk); #1;
        axi.arid = 2'd0; axi.araddr = 32'h010; axi.arlen = 8'd0; axi.arsize = 3'd2; axi.arburst = 2'b01;
        axi.awid = 2'd3; axi.awaddr = 32'h020; axi.awlen = 8'd1; axi.awsize = 3'd2; axi.awburst = 2'b01;
        axi.arvalid = 1'b1; axi.awvalid = 1'b1;
        @(negedge clk);
        chk("t4_first_arready", axi.arready, 1'b1);
        chk("t4_first_awready", axi.awready, 1'b0);
        @(posedge clk); #1;
        axi.arid = 2'd2; axi.araddr = 32'h040;
        n = 0;
        do begin @(negedge clk); n++; end while (!axi.arready && !axi.awready && n < 200);
        chk("t4_second_awready", axi.awready, 1'b1);
        chk("t4_second_arready", axi.arready, 1'b0);
        @(posedge clk); #1 axi.awvalid = 1'b0;
        w_send(1);
        n = 0;
        do begin @(negedge clk); n++; end while (!axi.arready && n < 200);
        if (!axi.arready) fail("t4_read2_timeout");
        @(posedge clk); #1 axi.arvalid = 1'b0;
        drain(300);

        // Error on write beat 1, then on read beat 0 only.
        obs_clear();
        do_write(2'd1, 32'hDFC, 1, 3'd2, 2'b01, -1, 1'b0);
        chk("t5_nb", obs_bresp.size(), 1);
        if (obs_bresp.size() == 1) chk("t5_bresp", obs_bresp[0], 2'b10);
        obs_clear();
        do_read(2'd1, 32'hEFC, 1, 3'd2, 2'b01);
        chk("t5_nr", obs_rresp.size(), 2);
        if (obs_rresp.size() == 2) begin
            chk("t5_rresp0", obs_rresp[0], 2'b10);
            chk("t5_rresp1", obs_rresp[1], 2'b00);
        end

        // WRAP read never touches MEM.
        obs_clear();
        do_read(2'd3, 32'h040, 1, 3'd2, 2'b10);
        chk("t6_nreq", obs_addr.size(), 0);
        chk("t6_nr", obs_rresp.size(), 2);
        if (obs_rresp.size() == 2) begin
            chk("t6_rresp0", obs_rresp[0], 2'b10);
            chk("t6_rresp1", obs_rresp[1], 2'b10);
            chk("t6_rdata1", obs_rdata[1], 32'h0);
        end

        // Reset while waiting on MEM; the late response must be ignored.
        slow = 1'b1;
        exp_read(2'd0, 32'h080, 0, 3'd2, 2'b01);
        ar_go(2'd0, 32'h080, 0, 3'd2, 2'b01);
        n = 0;
        while (mq.size() != 0 && n < 100) begin @(posedge clk); n++; end
        if (mq.size() != 0) fail("t6_grant_timeout");
        #1 rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_rvalid", axi.rvalid, 1'b0);
        chk("t6_rst_mem_req", mem_req, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        mq.delete(); rq.delete(); bq.delete();
        repeat (6) begin
            @(negedge clk);
            chk("t6_post_rst_rvalid", axi.rvalid, 1'b0);
        end
        slow = 1'b0;
        do_read(2'd1, 32'h084, 0, 3'd2, 2'b01);

        // Randomized traffic against the model.
        det = 1'b0;
        for (int i = 0; i < 60; i++) begin
            n = int'($urandom_range(0, 9));
            burst = (n < 4) ? 2'b01 : (n < 8) ? 2'b00 : (n == 8) ? 2'b10 : 2'b11;
            len = ($urandom_range(0, 5) == 0) ? 15 : int'($urandom_range(0, 7));
            size = 3'($urandom_range(0, 2));
            a = $urandom_range(0, 4096 - ((len + 1) << size));
            if ($urandom_range(0, 1) == 0)
                do_read(2'($urandom), a, len, size, burst);
            else
                do_write(2'($urandom), a, len, size, burst,
                         ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, len)) : -1, 1'b0);
        end

        // Longest burst: 256 beats.
        obs_clear();
        do_read(2'd2, 32'h000, 255, 3'd0, 2'b01);
        chk("len255_nbeats", obs_rlast.size(), 256);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
